lsu_unit: RTL

- Load-store unit directly downstream of the processor core's data-memory port.
- Consumes the core's mem_req/mem_we/mem_size/mem_addr/mem_wd and returns read data plus the stall_i signal the core freezes on.
- Registers each request, drives the data memory with byte enables and lane-replicated write data, and waits for memory ready.
- Aligns and sign/zero-extends load data back to the core.

---
 rtl/lsu_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lsu_unit.sv
// Load-store unit between the core data port and data memory.
// Captures one request at a time, drives memory with byte enables and
// lane-replicated store data, and aligns/extends load data to the core.
module lsu_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        latch_s;

  // Byte-enable pattern for a given access size and low address bits.
  function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0, 3'd4: calc_be = 4'b0001 << off;
      3'd1, 3'd5: calc_be = off[1] ? 4'b1100 : 4'b0011;
      3'd2:       calc_be = 4'b1111;
      default:    calc_be = 4'b0000;
    endcase
  endfunction

  // Store data replicated across every lane the access might land in.
  function automatic logic [31:0] calc_wd(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      3'd0, 3'd4: calc_wd = {4{wd[7:0]}};
      3'd1, 3'd5: calc_wd = {2{wd[15:0]}};
      default:    calc_wd = wd;
    endcase
  endfunction

  // Select the addressed byte/half from the memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] size, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      3'd0:    load_extract = {{24{b[7]}}, b};
      3'd4:    load_extract = {24'd0, b};
      3'd1:    load_extract = {{16{h[15]}}, h};
      3'd5:    load_extract = {16'd0, h};
      3'd2:    load_extract = word;
      default: load_extract = 32'd0;
    endcase
  endfunction

  // State register; reset always returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a trap drop or a memory completion ends BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (core_req_i) state_d = ST_BUSY;
        else            state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (!core_req_i || mem_ready_i) state_d = ST_IDLE;
        else                            state_d = ST_BUSY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture values; only loaded when a new request arrives in IDLE.
  always_comb begin
    latch_s = (state_q == ST_IDLE) && core_req_i;
    if (latch_s) begin
      addr_d = core_addr_i;
      we_d   = core_we_i;
      size_d = core_size_i;
      be_d   = calc_be(core_size_i, core_addr_i[1:0]);
      wd_d   = calc_wd(core_size_i, core_wd_i);
    end else begin
      addr_d = addr_q;
      we_d   = we_q;
      size_d = size_q;
      be_d   = be_q;
      wd_d   = wd_q;
    end
  end

  // Request registers; held stable while the memory is waiting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= 32'd0;
      we_q   <= 1'b0;
      size_q <= 3'd0;
      be_q   <= 4'd0;
      wd_q   <= 32'd0;
    end else begin
      addr_q <= addr_d;
      we_q   <= we_d;
      size_q <= size_d;
      be_q   <= be_d;
      wd_q   <= wd_d;
    end
  end

  // Output logic: stall, memory request qualifiers and load return data.
  always_comb begin
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    core_rd_o    = 32'd0;
    if (rst_i) begin
      core_stall_o = core_req_i;
    end else begin
      case (state_q)
        ST_IDLE: begin
          core_stall_o = core_req_i;
        end
        ST_BUSY: begin
          mem_req_o    = core_req_i;
          mem_we_o     = we_q & core_req_i;
          core_stall_o = core_req_i & ~mem_ready_i;
          if (core_req_i && mem_ready_i && !we_q) begin
            core_rd_o = load_extract(size_q, addr_q[1:0], mem_rd_i);
          end else begin
            core_rd_o = 32'd0;
          end
        end
        default: begin
          core_stall_o = 1'b0;
        end
      endcase
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_be_o   = be_q;
  assign mem_wd_o   = wd_q;

endmodule
